// File: rtl/bpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bpu_pkg : branch type encodings and BTB/RAS entry field widths       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package bpu_pkg;

    typedef enum logic [1:0] {
        TYPE_COND = 2'b00,
        TYPE_CALL = 2'b01,
        TYPE_RET  = 2'b10,
        TYPE_JMP  = 2'b11
    } br_type_e;

    localparam int TYPE_W     = 2;
    localparam int TGT_W      = 30;
    localparam int RAS_DATA_W = 30;

endpackage : bpu_pkg
`default_nettype wire

// File: rtl/bpu_ras.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bpu_ras : circular return-address stack with checkpoint restore      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bpu_ras
    import bpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [RAS_DATA_W-1:0] push_data_i,
    input  logic                  restore_i,
    input  logic [PTR_W-1:0]      restore_ptr_i,
    input  br_type_e              restore_type_i,
    input  logic [RAS_DATA_W-1:0] restore_data_i,
    output logic [PTR_W-1:0]      top_o,
    output logic [RAS_DATA_W-1:0] top_data_o
);

    logic [RAS_DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      top_d;
    logic [PTR_W-1:0]      top_q;

    // Pointer arithmetic wraps naturally: overflow overwrites the oldest slot.
    always_comb begin
        top_d = top_q;
        if (restore_i) begin
            case (restore_type_i)
                TYPE_CALL: top_d = restore_ptr_i + PTR_W'(1);
                TYPE_RET:  top_d = restore_ptr_i - PTR_W'(1);
                default:   top_d = restore_ptr_i;
            endcase
        end else if (push_i) begin
            top_d = top_q + PTR_W'(1);
        end else if (pop_i) begin
            top_d = top_q - PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            top_q <= '0;
        end else begin
            top_q <= top_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (restore_i) begin
                if (restore_type_i == TYPE_CALL) begin
                    mem_q[restore_ptr_i] <= restore_data_i;
                end
            end else if (push_i) begin
                mem_q[top_q] <= push_data_i;
            end
        end
    end

    assign top_o      = top_q;
    assign top_data_o = mem_q[top_q - PTR_W'(1)];

endmodule : bpu_ras
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_predictor : fetch-group BTB + counters + speculative RAS      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module branch_predictor
    import bpu_pkg::*;
#(
    parameter int FETCH_W     = 4,
    parameter int BTB_ENTRIES = 128,
    parameter int TAG_W       = 10,
    parameter int RAS_DEPTH   = 8,
    parameter int UPD_PORTS   = 2,
    parameter int CTR_W       = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [31:0]                           fetch_pc,
    input  logic                                  fetch_fire,
    output logic [31:0]                           pred_next_pc,
    output logic [FETCH_W-1:0]                    pred_taken,
    output logic [FETCH_W-1:0]                    pred_valid,
    output logic [$clog2(RAS_DEPTH)-1:0]          pred_ras_ptr,
    input  logic [UPD_PORTS-1:0]                  upd_valid,
    input  logic [32*UPD_PORTS-1:0]               upd_pc,
    input  logic [UPD_PORTS-1:0]                  upd_taken,
    input  logic [32*UPD_PORTS-1:0]               upd_target,
    input  logic [2*UPD_PORTS-1:0]                upd_type,
    input  logic [UPD_PORTS-1:0]                  upd_mispred,
    input  logic [$clog2(RAS_DEPTH)*UPD_PORTS-1:0] upd_ras_ptr,
    output logic [31:0]                           stat_lookups,
    output logic [31:0]                           stat_mispreds
);

    localparam int OFF_W = $clog2(FETCH_W);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int GRP_W = 30 - OFF_W;
    localparam logic [CTR_W-1:0] CTR_INIT = {1'b1, {(CTR_W-1){1'b0}}};

    logic [BTB_ENTRIES-1:0] btb_vld_q;
    logic [TAG_W-1:0]       btb_tag_q  [BTB_ENTRIES];
    br_type_e               btb_type_q [BTB_ENTRIES];
    logic [TGT_W-1:0]       btb_tgt_q  [BTB_ENTRIES];
    logic [CTR_W-1:0]       btb_ctr_q  [BTB_ENTRIES];
    logic [31:0]            lookups_q;
    logic [31:0]            mispreds_q;

    logic [29:0]            slot_word [FETCH_W];
    logic [IDX_W-1:0]       slot_idx  [FETCH_W];
    logic [FETCH_W-1:0]     slot_vld;
    logic [FETCH_W-1:0]     slot_hit;
    logic [OFF_W-1:0]       fetch_off;
    logic                   hit_found;
    logic [OFF_W-1:0]       hit_slot;
    logic [IDX_W-1:0]       hit_idx;
    br_type_e               hit_type;
    logic [GRP_W-1:0]       next_grp;
    logic [31:0]            seq_pc;

    logic [PTR_W-1:0]       ras_top;
    logic [RAS_DATA_W-1:0]  ras_top_data;
    logic                   ras_push;
    logic                   ras_pop;
    logic [RAS_DATA_W-1:0]  ras_push_data;

    logic [UPD_PORTS-1:0]   mis;
    logic                   redirect;
    logic [PTR_W-1:0]       rd_ptr;
    br_type_e               rd_type;
    logic [RAS_DATA_W-1:0]  rd_data;

    logic [IDX_W-1:0]       u_idx    [UPD_PORTS];
    logic [TAG_W-1:0]       u_tag    [UPD_PORTS];
    logic [CTR_W-1:0]       u_ctr_up [UPD_PORTS];
    logic [CTR_W-1:0]       u_ctr_dn [UPD_PORTS];
    logic [UPD_PORTS-1:0]   u_hit;
    logic                   unused_bits;

    assign fetch_off = fetch_pc[OFF_W+1:2];

    // Per-slot lookup; the lowest qualifying slot terminates the group.
    always_comb begin
        slot_vld  = '0;
        slot_hit  = '0;
        hit_found = 1'b0;
        hit_slot  = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            slot_word[i] = {fetch_pc[31:OFF_W+2], OFF_W'(i)};
            slot_idx[i]  = slot_word[i][IDX_W-1:0];
            slot_vld[i]  = (OFF_W'(i) >= fetch_off);
            slot_hit[i]  = slot_vld[i] && btb_vld_q[slot_idx[i]]
                        && (btb_tag_q[slot_idx[i]] == slot_word[i][IDX_W+TAG_W-1:IDX_W])
                        && btb_ctr_q[slot_idx[i]][CTR_W-1];
        end
        for (int i = FETCH_W - 1; i >= 0; i--) begin
            if (slot_hit[i]) begin
                hit_found = 1'b1;
                hit_slot  = OFF_W'(i);
            end
        end
    end

    assign hit_idx  = slot_idx[hit_slot];
    assign hit_type = btb_type_q[hit_idx];
    assign next_grp = fetch_pc[31:OFF_W+2] + GRP_W'(1);
    assign seq_pc   = {next_grp, {(OFF_W+2){1'b0}}};

    always_comb begin
        pred_valid = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            pred_valid[i] = slot_vld[i] && (!hit_found || (OFF_W'(i) <= hit_slot));
        end
    end

    assign pred_taken   = hit_found ? (FETCH_W'(1) << hit_slot) : '0;
    assign pred_next_pc = !hit_found             ? seq_pc :
                          (hit_type == TYPE_RET) ? {ras_top_data, 2'b00} :
                                                   {btb_tgt_q[hit_idx], 2'b00};
    assign pred_ras_ptr = ras_top;

    assign ras_push      = fetch_fire && !redirect && hit_found && (hit_type == TYPE_CALL);
    assign ras_pop       = fetch_fire && !redirect && hit_found && (hit_type == TYPE_RET);
    assign ras_push_data = slot_word[hit_slot] + 30'd1;

    // Oldest mispredicting port owns the RAS restore.
    always_comb begin
        mis      = upd_valid & upd_mispred;
        redirect = |mis;
        rd_ptr   = '0;
        rd_type  = TYPE_COND;
        rd_data  = '0;
        for (int p = UPD_PORTS - 1; p >= 0; p--) begin
            if (mis[p]) begin
                rd_ptr  = upd_ras_ptr[p*PTR_W +: PTR_W];
                rd_type = br_type_e'(upd_type[p*2 +: 2]);
                rd_data = upd_pc[p*32+2 +: 30] + 30'd1;
            end
        end
    end

    bpu_ras #(
        .DEPTH (RAS_DEPTH),
        .PTR_W (PTR_W)
    ) u_ras (
        .clk            (clk),
        .reset          (reset),
        .push_i         (ras_push),
        .pop_i          (ras_pop),
        .push_data_i    (ras_push_data),
        .restore_i      (redirect),
        .restore_ptr_i  (rd_ptr),
        .restore_type_i (rd_type),
        .restore_data_i (rd_data),
        .top_o          (ras_top),
        .top_data_o     (ras_top_data)
    );

    always_comb begin
        u_hit = '0;
        for (int p = 0; p < UPD_PORTS; p++) begin
            u_idx[p]    = upd_pc[p*32+2 +: IDX_W];
            u_tag[p]    = upd_pc[p*32+IDX_W+2 +: TAG_W];
            u_hit[p]    = btb_vld_q[u_idx[p]] && (btb_tag_q[u_idx[p]] == u_tag[p]);
            u_ctr_up[p] = (btb_ctr_q[u_idx[p]] == '1) ? btb_ctr_q[u_idx[p]]
                                                      : btb_ctr_q[u_idx[p]] + CTR_W'(1);
            u_ctr_dn[p] = (btb_ctr_q[u_idx[p]] == '0) ? btb_ctr_q[u_idx[p]]
                                                      : btb_ctr_q[u_idx[p]] - CTR_W'(1);
        end
    end

    // Later loop iterations override earlier ones, so the highest port wins a shared index.
    always_ff @(posedge clk) begin
        if (reset) begin
            btb_vld_q <= '0;
        end else begin
            for (int p = 0; p < UPD_PORTS; p++) begin
                if (upd_valid[p]) begin
                    if (upd_taken[p]) begin
                        btb_vld_q[u_idx[p]]  <= 1'b1;
                        btb_tag_q[u_idx[p]]  <= u_tag[p];
                        btb_type_q[u_idx[p]] <= br_type_e'(upd_type[p*2 +: 2]);
                        btb_tgt_q[u_idx[p]]  <= upd_target[p*32+2 +: TGT_W];
                        btb_ctr_q[u_idx[p]]  <= u_hit[p] ? u_ctr_up[p] : CTR_INIT;
                    end else if (u_hit[p]) begin
                        btb_ctr_q[u_idx[p]]  <= u_ctr_dn[p];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lookups_q  <= '0;
            mispreds_q <= '0;
        end else begin
            lookups_q  <= lookups_q + {31'd0, fetch_fire};
            mispreds_q <= mispreds_q + 32'($countones(mis));
        end
    end

    assign stat_lookups  = lookups_q;
    assign stat_mispreds = mispreds_q;

    assign unused_bits = ^{fetch_pc[1:0], upd_pc, upd_target};

endmodule : branch_predictor
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_branch_predictor : directed self-checking bench                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_branch_predictor;

    localparam int FW = 4;
    localparam int UP = 2;
    localparam int PW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     fetch_pc;
    logic            fetch_fire;
    logic [31:0]     pred_next_pc;
    logic [FW-1:0]   pred_taken;
    logic [FW-1:0]   pred_valid;
    logic [PW-1:0]   pred_ras_ptr;
    logic [UP-1:0]   upd_valid;
    logic [32*UP-1:0] upd_pc;
    logic [UP-1:0]   upd_taken;
    logic [32*UP-1:0] upd_target;
    logic [2*UP-1:0] upd_type;
    logic [UP-1:0]   upd_mispred;
    logic [PW*UP-1:0] upd_ras_ptr;
    logic [31:0]     stat_lookups;
    logic [31:0]     stat_mispreds;

    int errors = 0;
    int checks = 0;

    branch_predictor dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_pc      (fetch_pc),
        .fetch_fire    (fetch_fire),
        .pred_next_pc  (pred_next_pc),
        .pred_taken    (pred_taken),
        .pred_valid    (pred_valid),
        .pred_ras_ptr  (pred_ras_ptr),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_type      (upd_type),
        .upd_mispred   (upd_mispred),
        .upd_ras_ptr   (upd_ras_ptr),
        .stat_lookups  (stat_lookups),
        .stat_mispreds (stat_mispreds)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr_upd();
        upd_valid   = '0;
        upd_pc      = '0;
        upd_taken   = '0;
        upd_target  = '0;
        upd_type    = '0;
        upd_mispred = '0;
        upd_ras_ptr = '0;
    endtask

    task automatic set_upd(input int p, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic [1:0] ty,
                           input logic mp, input logic [PW-1:0] ptr);
        upd_valid[p]             = 1'b1;
        upd_pc[p*32 +: 32]       = pc;
        upd_taken[p]             = tk;
        upd_target[p*32 +: 32]   = tgt;
        upd_type[p*2 +: 2]       = ty;
        upd_mispred[p]           = mp;
        upd_ras_ptr[p*PW +: PW]  = ptr;
    endtask

    task automatic look(input logic [31:0] pc);
        fetch_pc = pc;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        fetch_pc   = '0;
        fetch_fire = 1'b0;
        clr_upd();
        tick();
        tick();
        reset = 1'b0;

        // Test 1: empty BTB gives sequential prediction
        look(32'h1000);
        chk("t1_next",     pred_next_pc, 32'h1010);
        chk("t1_valid",    {28'd0, pred_valid}, 32'hF);
        chk("t1_taken",    {28'd0, pred_taken}, 32'h0);
        chk("t1_rasptr",   {29'd0, pred_ras_ptr}, 32'h0);
        chk("t1_lookups",  stat_lookups, 32'd0);
        chk("t1_mispreds", stat_mispreds, 32'd0);
        look(32'h1008);
        chk("t1_offvalid", {28'd0, pred_valid}, 32'hC);
        chk("t1_offnext",  pred_next_pc, 32'h1010);

        // Test 2: conditional allocate, then train down
        set_upd(0, 32'h1008, 1'b1, 32'h2000, 2'b00, 1'b0, 3'd0);
        tick();
        clr_upd();
        look(32'h1000);
        chk("t2_taken", {28'd0, pred_taken}, 32'h4);
        chk("t2_valid", {28'd0, pred_valid}, 32'h7);
        chk("t2_next",  pred_next_pc, 32'h2000);
        set_upd(0, 32'h1008, 1'b0, 32'h0, 2'b00, 1'b0, 3'd0);
        tick();
        tick();
        clr_upd();
        look(32'h1000);
        chk("t2_seq_next",  pred_next_pc, 32'h1010);
        chk("t2_seq_taken", {28'd0, pred_taken}, 32'h0);

        // Test 3: call/return pair through the RAS
        set_upd(0, 32'h1004, 1'b1, 32'h3000, 2'b01, 1'b0, 3'd0);
        set_upd(1, 32'h3000, 1'b1, 32'h0,    2'b10, 1'b0, 3'd0);
        tick();
        clr_upd();
        fetch_fire = 1'b1;
        look(32'h1000);
        chk("t3_call_next",  pred_next_pc, 32'h3000);
        chk("t3_call_taken", {28'd0, pred_taken}, 32'h2);
        chk("t3_call_valid", {28'd0, pred_valid}, 32'h3);
        chk("t3_call_ptr",   {29'd0, pred_ras_ptr}, 32'd0);
        tick();
        look(32'h3000);
        chk("t3_ret_ptr",   {29'd0, pred_ras_ptr}, 32'd1);
        chk("t3_ret_next",  pred_next_pc, 32'h1008);
        chk("t3_ret_taken", {28'd0, pred_taken}, 32'h1);
        tick();
        fetch_fire = 1'b0;
        #1;
        chk("t3_pop_ptr", {29'd0, pred_ras_ptr}, 32'd0);

        // Test 4: nine consecutive calls wrap the stack
        set_upd(0, 32'h500C, 1'b1, 32'h3000, 2'b01, 1'b0, 3'd0);
        tick();
        clr_upd();
        fetch_fire = 1'b1;
        look(32'h500C);
        chk("t4_c0_taken", {28'd0, pred_taken}, 32'h8);
        chk("t4_c0_valid", {28'd0, pred_valid}, 32'h8);
        tick();
        look(32'h1000);
        for (int n = 0; n < 8; n++) tick();
        fetch_fire = 1'b0;
        look(32'h3000);
        chk("t4_wrap_ptr",  {29'd0, pred_ras_ptr}, 32'd1);
        chk("t4_overwrite", pred_next_pc, 32'h1008);
        chk("t4_noX", {31'd0, $isunknown({pred_next_pc, pred_taken, pred_valid, pred_ras_ptr})}, 32'd0);
        chk("t4_lookups", stat_lookups, 32'd11);

        // Test 5: dual mispredict, oldest port restores; same-cycle fetch ignored
        set_upd(0, 32'h7010, 1'b1, 32'h7100, 2'b01, 1'b1, 3'd3);
        set_upd(1, 32'h7020, 1'b0, 32'h0,    2'b00, 1'b1, 3'd5);
        fetch_fire = 1'b1;
        look(32'h1000);
        tick();
        clr_upd();
        fetch_fire = 1'b0;
        look(32'h3000);
        chk("t5_top",      {29'd0, pred_ras_ptr}, 32'd4);
        chk("t5_ras3",     pred_next_pc, 32'h7014);
        chk("t5_mispreds", stat_mispreds, 32'd2);
        chk("t5_lookups",  stat_lookups, 32'd12);
        look(32'h7010);
        chk("t5_alloc_next", pred_next_pc, 32'h7100);

        // Test 6: same-index write conflict, then reset wins over an update
        set_upd(0, 32'h9020, 1'b1, 32'hB000, 2'b00, 1'b0, 3'd0);
        set_upd(1, 32'h9020, 1'b1, 32'hA000, 2'b00, 1'b0, 3'd0);
        tick();
        clr_upd();
        look(32'h9020);
        chk("t6_port1_wins", pred_next_pc, 32'hA000);
        chk("t6_taken",      {28'd0, pred_taken}, 32'h1);
        reset      = 1'b1;
        fetch_fire = 1'b1;
        set_upd(0, 32'h9040, 1'b1, 32'hC000, 2'b00, 1'b1, 3'd2);
        tick();
        reset      = 1'b0;
        fetch_fire = 1'b0;
        clr_upd();
        look(32'h9020);
        chk("t6_rst_next",  pred_next_pc, 32'h9030);
        chk("t6_rst_taken", {28'd0, pred_taken}, 32'h0);
        look(32'h9040);
        chk("t6_rst_upd",   pred_next_pc, 32'h9050);
        look(32'h3000);
        chk("t6_rst_ret",   pred_next_pc, 32'h3010);
        chk("t6_rst_ptr",   {29'd0, pred_ras_ptr}, 32'd0);
        chk("t6_rst_look",  stat_lookups, 32'd0);
        chk("t6_rst_mis",   stat_mispreds, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_branch_predictor
`default_nettype wire

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameters: FETCH_W, default 4, instructions per fetch group (power of 2); BTB_ENTRIES, default 128, BTB depth (power of 2, multiple of FETCH_W); TAG_W, default 10, BTB tag width; RAS_DEPTH, default 8, return stack entries (power of 2); UPD_PORTS, default 2, execute-stage update channels; CTR_W, default 2, direction-counter width.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high.
- fetch_pc, in, 32, fetch address.
- fetch_fire, in, 1, fetch group accepted this cycle.
- pred_next_pc, out, 32, predicted next fetch address.
- pred_taken, out, FETCH_W, one-hot slot predicted taken.
- pred_valid, out, FETCH_W, slots to issue.
- pred_ras_ptr, out, log2(RAS_DEPTH), RAS checkpoint for the group.
- upd_valid, in, UPD_PORTS, update strobe per port; port 0 is oldest.
- upd_pc, in, 32*UPD_PORTS, branch PC.
- upd_taken, in, UPD_PORTS, resolved direction.
- upd_target, in, 32*UPD_PORTS, resolved target.
- upd_type, in, 2*UPD_PORTS, branch type: 00 cond, 01 call, 10 return, 11 direct jump.
- upd_mispred, in, UPD_PORTS, port mispredicted.
- upd_ras_ptr, in, log2(RAS_DEPTH)*UPD_PORTS, checkpoint carried with the branch.
- stat_lookups, out, 32, count of fired groups.
- stat_mispreds, out, 32, count of mispredicted updates.

Function
REQ-003 SHALL predict combinationally (0-cycle latency) from fetch_pc; slot i address = {fetch_pc[31:log2(FETCH_W)+2], i, 2'b00}.
REQ-004 SHALL treat slots below fetch_pc's in-group offset as invalid.
REQ-005 SHALL compute index = addr[IDX_W+1:2] and tag = addr[IDX_W+TAG_W+1:IDX_W+2] for every slot; IDX_W = log2(BTB_ENTRIES).
REQ-006 SHALL treat a slot as a hit when it is valid, its entry is valid, its tag matches, and its counter MSB is 1 (types 01/10/11 are always taken on hit).
REQ-007 SHALL select the lowest hit slot k: pred_taken = one-hot k; pred_valid = valid slots <= k.
REQ-008 On hit, pred_next_pc SHALL be {ras[top-1],2'b00} for type 10, else {target,2'b00}.
REQ-009 On no hit, pred_next_pc SHALL be the next aligned group (pc + 4*FETCH_W, low bits cleared); pred_taken = 0; pred_valid = valid slots.
REQ-010 pred_ras_ptr SHALL equal the current RAS top before this group's speculative update.
REQ-011 On fetch_fire with no redirect, the RAS SHALL update speculatively: predicted call pushes (slot addr + 4)[31:2]; predicted return pops; the top pointer wraps modulo RAS_DEPTH (overflow overwrites the oldest entry; underflow wraps).
REQ-012 Redirect = any upd_valid & upd_mispred. The oldest mispredicting port m SHALL restore top to upd_ras_ptr[m] adjusted by its own type: call writes ras[ptr] = (upd_pc+4)[31:2] and sets top = ptr+1; return sets top = ptr-1; otherwise top = ptr. Redirect overrides the same-cycle fetch update.
REQ-013 Each valid update SHALL write the BTB on the next edge. If taken and the entry misses (invalid or tag mismatch), it allocates {valid, tag, type, target[31:2]} with counter = 2^(CTR_W-1). If the entry hits, the counter saturates up when taken (with target/type rewritten) and saturates down when not taken. A not-taken miss SHALL cause no write.
REQ-014 When multiple ports write the same index in one cycle, the highest-numbered port SHALL win.
REQ-015 stat_lookups SHALL increment on fetch_fire; stat_mispreds SHALL add popcount(upd_valid & upd_mispred); both wrap at 2^32.

Reset
REQ-016 On reset, all BTB valid bits, the RAS top and both stat counters SHALL clear to 0; BTB/RAS payloads are not reset.
REQ-017 Immediately after reset, outputs SHALL be pred_taken = 0, pred_valid = offset mask, pred_next_pc = sequential, pred_ras_ptr = 0.
REQ-018 Reset asserted mid-operation SHALL take priority over all updates in that cycle.

Structure
REQ-019 The type encodings (TYPE_COND/CALL/RET/JMP) and the BTB entry field widths SHALL live in the shared package bpu_pkg.
REQ-020 The RAS (push/pop/restore, wrap) SHALL be the sub-module bpu_ras; the BTB and counters are inline.

Verification
REQ-021 Test 1: reset, then fetch_pc=0x1000 -> pred_next_pc=0x1010, pred_valid=1111, pred_taken=0.
REQ-022 Test 2: update port0 cond taken pc=0x1008 target=0x2000, then fetch 0x1000 -> pred_taken=0100, pred_valid=0111, pred_next_pc=0x2000; two not-taken updates -> sequential again.
REQ-023 Test 3: train call at 0x1004 and return at 0x3000; fetch-fire 0x1000 then 0x3000 -> second group pred_next_pc=0x1008.
REQ-024 Test 4: RAS_DEPTH+1 consecutive predicted calls -> top wraps to 1 and the oldest entry is overwritten; no X on outputs.
REQ-025 Test 5: port0 and port1 both mispredict in one cycle, ras_ptr 3 (call) and 5 -> top=4, ras[3]=upd_pc0+4, stat_mispreds+=2.
REQ-026 Test 6: both ports update the same index with different targets -> port1's target is predicted; reset asserted in the same cycle -> BTB empty.
